mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the pipeline and the byte-wide unified RAM. It serves two requesters: the data port driven by `stage_mem` (byte/half/word loads and stores) and the instruction-fetch port (word reads). Each transaction becomes a sequence of single-byte RAM cycles, and completion is reported with a one-cycle done pulse. `stage_mem` stalls on `!mem_done`.

## Interface
- `RAM_ADDR_W`, default 17: RAM address width; `ram_addr` carries the low bits of the byte address.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_read` in 1: data-port load request, level, held until `mem_done`.
- `mem_write` in 1: data-port store request, level, held until `mem_done`.
- `mem_signed` in 1: 1 sign-extends load data, 0 zero-extends.
- `mem_addr_i` in `MemAddrBus` (32): data byte address.
- `mem_len_i` in 2: 00 byte, 01 half, 10 word, 11 treated as word.
- `mem_w_data` in `MemDataBus` (32): store data, little-endian, low bytes used.
- `mem_r_data` out 32: extended load data, valid while `mem_done`=1.
- `mem_done` out 1: one-cycle data-port completion pulse.
- `if_read` in 1: fetch request, level.
- `if_addr` in 32: fetch address.
- `if_flush` in 1: cancel the fetch in flight (redirect).
- `if_data` out 32: fetched instruction word, valid while `if_done`=1.
- `if_done` out 1: one-cycle fetch completion pulse.
- `ram_addr` out `RAM_ADDR_W`: RAM byte address.
- `ram_wr` out 1: 1 write, 0 read.
- `ram_dout` out 8: byte to RAM.
- `ram_din` in 8: byte from RAM, valid one cycle after its address is driven with `ram_wr`=0.

## Operation
- FSM states:
  - IDLE: accepts a request and latches base address, length n (1/2/4), signed flag, store data and owner (DATA/IF). Clears the byte counter `cnt`.
  - READ: issues one byte per cycle, then collects the last byte.
  - WRITE: issues one byte per cycle.
  - DONE: pulses the owner's done signal.
- Arbitration in IDLE:
  - A data request beats `if_read`.
  - If `mem_read` and `mem_write` are both high, the write wins.
  - With no request, the FSM stays in IDLE.
- READ:
  - While `cnt`<n, drive `ram_addr`=base+`cnt` with `ram_wr`=0.
  - When `cnt`>=1, capture `ram_din` into byte `cnt`-1 of the assembly register.
  - When `cnt`==n, capture the last byte and go to DONE.
- WRITE:
  - For `cnt`=0..n-1, drive `ram_addr`=base+`cnt`, `ram_wr`=1 and `ram_dout`=byte `cnt` of the store data.
  - After `cnt`=n-1, go to DONE.
- DONE:
  - Assert exactly one of `mem_done`/`if_done` for one cycle, with registered data that is extended per n and the signed flag. Fetches are always zero-extended words.
  - Return to IDLE. Requests are resampled there, so a held request starts a new transaction.
- Address arithmetic is modulo 2^32 and is then truncated to `RAM_ADDR_W`. Misaligned accesses are legal and are issued byte-sequentially.
- Request inputs are ignored once a transaction has started (no aborts), except for `if_flush`.
- `if_flush`:
  - Owner IF in READ: abort to IDLE next cycle, no `if_done`.
  - Owner IF in DONE: suppress `if_done`.
  - Owner DATA: no effect.
  - In IDLE, a fetch is not accepted in a cycle where `if_flush`=1.

## Timing
- Reset values: state IDLE; `ram_wr`=0, `ram_addr`=0, `ram_dout`=0, `mem_done`=0, `if_done`=0, `mem_r_data`=0, `if_data`=0.
- Reset mid-transaction: the next edge returns to IDLE, and no write is issued after that edge. A partially written store is not rolled back.
- Latency, with the request first seen in IDLE at cycle 0:
  - Reads: READ occupies cycles 1..n+1, done at cycle n+2 (word 6, half 4, byte 3).
  - Writes: WRITE occupies cycles 1..n, done at cycle n+1 (word 5, half 3, byte 2).
- Back-to-back transactions have at least one IDLE cycle between them.
- Done pulses are never asserted in IDLE, READ or WRITE.
- All outputs are registered.
- `ram_wr` is 1 only in WRITE.

## Structure
- Shared `defines.v` holds the bus macros (`MemAddrBus`, `MemDataBus`) and the length encodings (`LenByte`, `LenHalf`, `LenWord`).
- The state encoding and owner encoding are local parameters.
- The block is a single module with no natural sub-module.
- The extension logic is an inline function.

## Test plan
- LB at address 0x10 holding 0x80, `mem_signed`=1 -> `mem_r_data`=0xFFFFFF80 at cycle 3. With `mem_signed`=0 the result is 0x00000080.
- SW 0xDEADBEEF to 0x100 -> RAM bytes 0x100..0x103 = EF BE AD DE, `ram_wr` high for 4 cycles, `mem_done` at cycle 5. A following LW at 0x100 returns 0xDEADBEEF at cycle 6.
- `if_read` and `mem_read` both raised in the same cycle -> the data load completes first, then the fetch. Exactly one done pulse per transaction.
- Fetch in flight with `if_flush` pulsed at cycle 2 -> no `if_done`, IDLE at cycle 3, the new fetch address is accepted afterwards.
- `rst` asserted during cycle 2 of a word store -> IDLE and `ram_wr`=0 from the next edge. No done pulse.
- LH at 0x1FFFF with `RAM_ADDR_W`=17 -> the second byte comes from `ram_addr` 0x00000 (address wrap).

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared widths, length encodings, FSM/owner encodings and length decode
// for the byte-sequential memory controller.
package mem_ctrl_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_DATA = 1'b0,
    OWN_IF   = 1'b1
  } owner_e;

  // 2'b11 is treated as a word access.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Splits data-port and fetch transactions into single-byte RAM cycles and
// reports completion with a one-cycle done pulse per owner.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | arbitrate, latch base/len/sign/store data/owner, cnt = 0
// ST_READ  | issue byte addresses, assemble returning bytes
// ST_WRITE | issue one byte write per cycle
// ST_DONE  | registered done pulse and data visible, back to IDLE
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  mem_signed,
  input  logic [MEM_ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]            mem_len_i,
  input  logic [MEM_DATA_W-1:0] mem_w_data,
  output logic [31:0]           mem_r_data,
  output logic                  mem_done,
  input  logic                  if_read,
  input  logic [31:0]           if_addr,
  input  logic                  if_flush,
  output logic [31:0]           if_data,
  output logic                  if_done,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_wr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din
);

  state_e                  state_q, state_d;
  owner_e                  owner_q, owner_d;
  logic [31:0]             base_q, base_d;
  logic [2:0]              n_q, n_d;
  logic                    sgn_q, sgn_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [31:0]             asm_q, asm_d;
  logic [RAM_ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                    ram_wr_q, ram_wr_d;
  logic [7:0]              ram_dout_q, ram_dout_d;
  logic                    mem_done_q, mem_done_d;
  logic                    if_done_q, if_done_d;
  logic [31:0]             mem_r_data_q, mem_r_data_d;
  logic [31:0]             if_data_q, if_data_d;

  logic [31:0]             raw;
  logic [31:0]             addr_sum;
  logic                    drive_addr;
  logic                    drive_wr;
  logic                    unused_addr_hi;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] n,
                                         input logic sgn);
    case (n)
      3'd1:    return {{24{sgn & v[7]}}, v[7:0]};
      3'd2:    return {{16{sgn & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    base_d       = base_q;
    n_d          = n_q;
    sgn_d        = sgn_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    asm_d        = asm_q;
    ram_addr_d   = ram_addr_q;
    ram_wr_d     = 1'b0;
    ram_dout_d   = ram_dout_q;
    mem_done_d   = 1'b0;
    if_done_d    = 1'b0;
    mem_r_data_d = mem_r_data_q;
    if_data_d    = if_data_q;
    raw          = asm_q;
    drive_addr   = 1'b0;
    drive_wr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = 3'd0;
        asm_d = 32'd0;
        if (mem_write || mem_read) begin
          owner_d    = OWN_DATA;
          base_d     = mem_addr_i;
          n_d        = len_bytes(mem_len_i);
          sgn_d      = mem_signed;
          wdata_d    = mem_w_data;
          drive_addr = 1'b1;
          if (mem_write) begin
            state_d  = ST_WRITE;
            drive_wr = 1'b1;
          end else begin
            state_d  = ST_READ;
          end
        end else if (if_read && !if_flush) begin
          owner_d    = OWN_IF;
          base_d     = if_addr;
          n_d        = 3'd4;
          sgn_d      = 1'b0;
          state_d    = ST_READ;
          drive_addr = 1'b1;
        end
      end

      ST_READ: begin
        if (owner_q == OWN_IF && if_flush) begin
          state_d = ST_IDLE;
        end else begin
          // ram_din lags its address by one cycle, so cnt selects byte cnt-1.
          case (cnt_q)
            3'd1:    raw[7:0]   = ram_din;
            3'd2:    raw[15:8]  = ram_din;
            3'd3:    raw[23:16] = ram_din;
            3'd4:    raw[31:24] = ram_din;
            default: ;
          endcase
          asm_d = raw;
          if (cnt_q == n_q) begin
            state_d = ST_DONE;
            if (owner_q == OWN_DATA) begin
              mem_done_d   = 1'b1;
              mem_r_data_d = extend(raw, n_q, sgn_q);
            end else begin
              if_done_d = 1'b1;
              if_data_d = raw;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d < n_q) drive_addr = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (cnt_q == n_q - 3'd1) begin
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          drive_addr = 1'b1;
          drive_wr   = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    addr_sum = base_d + {29'd0, cnt_d};
    if (drive_addr) ram_addr_d = addr_sum[RAM_ADDR_W-1:0];
    if (drive_wr) begin
      ram_wr_d   = 1'b1;
      ram_dout_d = wdata_d[{cnt_d[1:0], 3'b000} +: 8];
    end
  end

  // The RAM only decodes the low address bits; the rest wrap away.
  assign unused_addr_hi = ^addr_sum[31:RAM_ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_DATA;
      base_q       <= 32'd0;
      n_q          <= 3'd0;
      sgn_q        <= 1'b0;
      wdata_q      <= 32'd0;
      cnt_q        <= 3'd0;
      asm_q        <= 32'd0;
      ram_addr_q   <= '0;
      ram_wr_q     <= 1'b0;
      ram_dout_q   <= 8'd0;
      mem_done_q   <= 1'b0;
      if_done_q    <= 1'b0;
      mem_r_data_q <= 32'd0;
      if_data_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      base_q       <= base_d;
      n_q          <= n_d;
      sgn_q        <= sgn_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      ram_addr_q   <= ram_addr_d;
      ram_wr_q     <= ram_wr_d;
      ram_dout_q   <= ram_dout_d;
      mem_done_q   <= mem_done_d;
      if_done_q    <= if_done_d;
      mem_r_data_q <= mem_r_data_d;
      if_data_q    <= if_data_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_wr     = ram_wr_q;
  assign ram_dout   = ram_dout_q;
  assign mem_done   = mem_done_q;
  assign if_done    = if_done_q;
  assign mem_r_data = mem_r_data_q;
  assign if_data    = if_data_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: byte-wide RAM model, expected responses queued
// by the stimulus and checked by an independent done monitor.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, mem_signed = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_w_data = '0;
  logic [1:0]  mem_len_i = '0;
  logic [31:0] mem_r_data;
  logic        mem_done;
  logic        if_read = 1'b0, if_flush = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_done;
  logic [16:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;

  mem_ctrl #(.RAM_ADDR_W(17)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_signed(mem_signed),
    .mem_addr_i(mem_addr_i), .mem_len_i(mem_len_i), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data), .mem_done(mem_done),
    .if_read(if_read), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:131071];
  always @(posedge clk) begin
    if (ram_wr) ram[ram_addr] <= ram_dout;
    ram_din <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int wr_cnt = 0;
  always @(negedge clk) if (ram_wr) wr_cnt++;

  typedef struct {
    logic        owner_if;
    logic [31:0] data;
    logic        chk_data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && (mem_done || if_done)) begin
      check("single_done", {31'd0, mem_done & if_done}, 32'd0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: cyc=%0d mem_done=%0b if_done=%0b required none",
                 cyc, mem_done, if_done);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_owner", {31'd0, if_done}, {31'd0, mon_e.owner_if});
        check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        if (mon_e.chk_data)
          check("done_data", if_done ? if_data : mem_r_data, mon_e.data);
      end
    end
  end

  function automatic int nbytes(input logic [1:0] len);
    return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
  endfunction

  task automatic data_txn(input bit wr, input bit also_rd, input logic [31:0] addr,
                          input logic [1:0] len, input bit sgn, input logic [31:0] wd,
                          input logic [31:0] exp_data);
    bit got = 0;
    @(posedge clk); #1;
    mem_write  = wr;
    mem_read   = !wr || also_rd;
    mem_addr_i = addr;
    mem_len_i  = len;
    mem_signed = sgn;
    mem_w_data = wd;
    exp_q.push_back('{1'b0, exp_data, !wr, cyc + nbytes(len) + (wr ? 1 : 2)});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_done) begin got = 1; break; end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL data_timeout: addr %h no mem_done within 20 cycles", addr);
    end
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input logic [31:0] exp_data);
    bit got = 0;
    @(posedge clk); #1;
    if_read = 1'b1;
    if_addr = addr;
    exp_q.push_back('{1'b1, exp_data, 1'b1, cyc + 6});
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_done) begin got = 1; break; end
    end
    if_read = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL fetch_timeout: addr %h no if_done within 20 cycles", addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit got;

    ram[17'h00010] = 8'h80;
    ram[17'h00100] = 8'h00; ram[17'h00101] = 8'h00;
    ram[17'h00102] = 8'h00; ram[17'h00103] = 8'h00;
    ram[17'h00104] = 8'h77;
    ram[17'h00200] = 8'h00; ram[17'h00201] = 8'h90;
    ram[17'h1FFFF] = 8'h34; ram[17'h00000] = 8'h12;
    ram[17'h00400] = 8'h00; ram[17'h00401] = 8'hEE;
    ram[17'h00402] = 8'h00; ram[17'h00403] = 8'h00;
    ram[17'h00500] = 8'h13; ram[17'h00501] = 8'h00;
    ram[17'h00502] = 8'h00; ram[17'h00503] = 8'h93;
    ram[17'h00600] = 8'h6F; ram[17'h00601] = 8'h00;
    ram[17'h00602] = 8'h40; ram[17'h00603] = 8'h00;
    ram[17'h00300] = 8'h00; ram[17'h00301] = 8'h00;
    ram[17'h00302] = 8'hA5; ram[17'h00303] = 8'hA5;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram_wr",     {31'd0, ram_wr},   32'd0);
    check("rst_ram_addr",   {15'd0, ram_addr}, 32'd0);
    check("rst_ram_dout",   {24'd0, ram_dout}, 32'd0);
    check("rst_mem_done",   {31'd0, mem_done}, 32'd0);
    check("rst_if_done",    {31'd0, if_done},  32'd0);
    check("rst_mem_r_data", mem_r_data,        32'd0);
    check("rst_if_data",    if_data,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // loads: sign/zero extension, byte and half
    data_txn(0, 0, 32'h0000_0010, 2'b00, 1, 32'd0, 32'hFFFF_FF80);
    data_txn(0, 0, 32'h0000_0010, 2'b00, 0, 32'd0, 32'h0000_0080);
    data_txn(0, 0, 32'h0000_0200, 2'b01, 1, 32'd0, 32'hFFFF_9000);
    data_txn(0, 0, 32'h0000_0200, 2'b01, 0, 32'd0, 32'h0000_9000);

    // word store then load back, aligned and misaligned, len 11 as word
    wr_cnt = 0;
    data_txn(1, 0, 32'h0000_0100, 2'b10, 0, 32'hDEAD_BEEF, 32'd0);
    check("sw_wr_cycles", 32'(wr_cnt), 32'd4);
    check("sw_byte0", {24'd0, ram[17'h100]}, 32'h0000_00EF);
    check("sw_byte1", {24'd0, ram[17'h101]}, 32'h0000_00BE);
    check("sw_byte2", {24'd0, ram[17'h102]}, 32'h0000_00AD);
    check("sw_byte3", {24'd0, ram[17'h103]}, 32'h0000_00DE);
    data_txn(0, 0, 32'h0000_0100, 2'b10, 1, 32'd0, 32'hDEAD_BEEF);
    data_txn(0, 0, 32'h0000_0101, 2'b10, 0, 32'd0, 32'h77DE_ADBE);
    data_txn(0, 0, 32'h0000_0100, 2'b11, 0, 32'd0, 32'hDEAD_BEEF);

    // address wrap and high-bit truncation
    data_txn(0, 0, 32'h0001_FFFF, 2'b01, 0, 32'd0, 32'h0000_1234);
    data_txn(0, 0, 32'hFFFE_0010, 2'b00, 0, 32'd0, 32'h0000_0080);

    // byte and half stores, the byte one with read also raised (write wins)
    wr_cnt = 0;
    data_txn(1, 1, 32'h0000_0400, 2'b00, 0, 32'hAABB_CC5A, 32'd0);
    check("sb_wr_cycles", 32'(wr_cnt), 32'd1);
    data_txn(1, 0, 32'h0000_0402, 2'b01, 0, 32'h1234_BEEF, 32'd0);
    data_txn(0, 0, 32'h0000_0400, 2'b10, 0, 32'd0, 32'hBEEF_EE5A);

    // plain fetch
    fetch_txn(32'h0000_0500, 32'h9300_0013);

    // data and fetch raised together: load first, then fetch
    @(posedge clk); #1;
    c0 = cyc;
    mem_read = 1'b1; mem_addr_i = 32'h0000_0100; mem_len_i = 2'b10; mem_signed = 1'b0;
    if_read = 1'b1; if_addr = 32'h0000_0500;
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b1, c0 + 6});
    exp_q.push_back('{1'b1, 32'h9300_0013, 1'b1, c0 + 13});
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_done) mem_read = 1'b0;
      if (if_done) begin if_read = 1'b0; got = 1; break; end
    end
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL arb_timeout: no if_done within 40 cycles");
    end
    mem_read = 1'b0; if_read = 1'b0;

    // fetch flushed at cycle 2, redirected fetch accepted at cycle 3
    @(posedge clk); #1;
    c0 = cyc;
    if_read = 1'b1; if_addr = 32'h0000_0500;
    exp_q.push_back('{1'b1, 32'h0040_006F, 1'b1, c0 + 9});
    @(posedge clk); #1;
    @(posedge clk); #1;
    if_flush = 1'b1; if_addr = 32'h0000_0600;
    @(posedge clk); #1;
    if_flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("flush_new_addr", {15'd0, ram_addr}, 32'h0000_0600);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_done) begin got = 1; break; end
    end
    if_read = 1'b0;
    if (!got) begin
      n_vec++; n_err++;
      $display("FAIL flush_timeout: no if_done for redirected fetch");
    end

    // reset during cycle 2 of a word store
    @(posedge clk); #1;
    wr_cnt = 0;
    mem_write = 1'b1; mem_addr_i = 32'h0000_0300; mem_len_i = 2'b10;
    mem_w_data = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; mem_write = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_ram_wr", {31'd0, ram_wr}, 32'd0);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_wr_cycles", 32'(wr_cnt), 32'd2);
    check("rst_mid_byte0", {24'd0, ram[17'h300]}, 32'h0000_0044);
    check("rst_mid_byte1", {24'd0, ram[17'h301]}, 32'h0000_0033);
    check("rst_mid_byte2", {24'd0, ram[17'h302]}, 32'h0000_00A5);

    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
